result_stream_tx: RTL and testbench
===================================

// Module: result_stream_tx
// PURPOSE
// - AXI4-Stream master that drains the C result matrix from the scheduler to the host/DMA.
// - Captures the flat C_matrix on GLOBAL_DONE into a shadow register so the scheduler is free immediately.
// - Streams the active N x N sub-matrix row-major, one element per beat, TLAST on the final element.
// PARAMETERS
// - DATA_WIDTH  32           element width, bits
// - SIZE        6            systolic array dimension; max supported N
// - ARRAY_SIZE  SIZE*SIZE    elements in the flat C vector
// PORTS
// - axi_clk        in   1                      single clock, all logic rising-edge
// - axi_rst        in   1                      asynchronous, active-high reset
// - N              in   4                      active matrix dimension, sampled on capture
// - GLOBAL_DONE    in   1                      scheduler completion; capture on rising edge
// - C_matrix       in   ARRAY_SIZE*DATA_WIDTH  flat result; element k at [(ARRAY_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH], k=r*SIZE+c
// - m_axis_data    out  DATA_WIDTH             stream data, registered
// - m_axis_valid   out  1                      stream valid, registered
// - m_axis_ready   in   1                      downstream ready
// - m_axis_last    out  1                      final beat of frame
// - m_axis_user    out  1                      row-end marker (see CONFIGURATION)
// - busy           out  1                      high from capture until final beat accepted
// - overrun        out  1                      sticky: GLOBAL_DONE edge while busy; cleared only by reset
// - n_err          out  1                      sticky: capture with N==0; cleared only by reset
// BEHAVIOUR
// - Reset (async, any cycle incl. mid-frame): state IDLE, all outputs 0, shadow/counters 0; partial frame dropped.
// - States: IDLE -> SEND -> IDLE. No other states.
// - IDLE: GLOBAL_DONE rising edge (registered previous value) sampled at edge t -> at t+1: shadow<=C_matrix,
//   n_act<=min(N,SIZE), busy=1, m_axis_valid=1, m_axis_data=element(0,0). Latency GLOBAL_DONE->first beat = 1 cycle.
// - N==0 at capture: no frame, stay IDLE, set n_err. N>SIZE: clamp to SIZE, no flag.
// - SEND: beat accepted when valid&&ready. On accept: advance (r,c); c wraps n_act-1->0 with r+1.
//   Next data loaded in same edge -> back-to-back beats at full throughput when ready held high.
// - valid, data, last, user held stable while valid&&!ready (AXI-S rule); valid never drops mid-frame.
// - m_axis_last=1 exactly when (r,c)==(n_act-1,n_act-1). Accept of last beat -> IDLE, valid=0, busy=0 next cycle.
// - N=1: single beat with last=1.
// - GLOBAL_DONE rising edge while busy (incl. same cycle as last accept): ignored, overrun set; no new frame.
//   Level held high across frame end does not retrigger (edge-detected only).
// - Elements with r or c >= n_act never emitted. Data passed unmodified, no arithmetic on payload.
// - Counters r,c: $clog2(SIZE) bits; index k = r*SIZE + c computed at full width, no truncation.
// CONFIGURATION
// - Macro RESULT_TX_ROW_MARK_EN.
// - Defined: m_axis_user=1 on every beat with c==n_act-1 (row end), held with data under backpressure.
// - Undefined: m_axis_user tied 0; no row-end logic synthesized. All other behaviour identical.
// STRUCTURE
// - Package matmul_pkg: DATA_WIDTH/SIZE defaults, tx_state_t enum {IDLE,SEND}, function elem_idx(r,c).
//   Package shared with the input FIFO buffer and scheduler.
// - Sub-module rc_counter: row/col counter with programmable wrap n_act, inc, last/row_end outputs.
// - Top: edge detect, shadow register, output register stage, FSM, sticky flags.
// TESTING
// - N=6, C[k]=k+1, ready=1: 36 beats on consecutive cycles, data 1..36, last only on beat 36, busy low after.
// - N=3, C[k]=k+1, ready=1: data 1,2,3,7,8,9,13,14,15; last on 15; 9 beats total.
// - N=4, ready toggled 1/0 each cycle: 16 beats, data/last stable while ready=0, no loss or duplicate.
// - GLOBAL_DONE re-pulsed mid-frame (N=2): frame completes with original data, overrun=1, no second frame.
// - N=0 capture -> no valid, n_err=1; N=9 -> 36 beats (clamped); axi_rst at beat 5 -> valid=0 at once, idle.
// - RESULT_TX_ROW_MARK_EN, N=3: m_axis_user=1 on beats 3,6,9 only; undefined: user always 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, state type and element indexing for the matmul result path.
// Shared with the input FIFO buffer and the scheduler.
package matmul_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned SIZE       = 6;
    localparam int unsigned ARRAY_SIZE = SIZE * SIZE;
    localparam int unsigned CNT_W      = $clog2(SIZE);
    localparam int unsigned IDX_W      = $clog2(ARRAY_SIZE);
    localparam int unsigned N_W        = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    // One registered stream beat (row-end marker is kept separately so it can compile out)
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } tx_beat_t;

    // Flat index k = r*SIZE + c, sized to hold ARRAY_SIZE-1 without truncation
    function automatic logic [IDX_W-1:0] elem_idx(input logic [CNT_W-1:0] r,
                                                  input logic [CNT_W-1:0] c);
        return IDX_W'(r) * IDX_W'(SIZE) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/result_stream_tx_rc_counter.sv
// Row/column position counter with programmable wrap; exposes the next position and its flags.
// Macro RESULT_TX_ROW_MARK_EN adds the next-position row-end output.
module rc_counter
    import matmul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] n_act_i,
    output logic [CNT_W-1:0] r_nxt_o,
    output logic [CNT_W-1:0] c_nxt_o,
    output logic             last_o,
    output logic             nxt_last_o
`ifdef RESULT_TX_ROW_MARK_EN
    ,
    output logic             nxt_row_end_o
`endif
);

    logic [CNT_W-1:0] r_q, c_q;
    logic [CNT_W-1:0] r_d, c_d;
    logic [CNT_W-1:0] n_max;

    assign n_max = n_act_i - CNT_W'(1);

    // Row-major advance: column wraps at n_act-1, row wraps after the final element
    always_comb begin
        r_nxt_o = r_q;
        c_nxt_o = c_q + CNT_W'(1);
        if (c_q == n_max) begin
            c_nxt_o = '0;
            r_nxt_o = (r_q == n_max) ? '0 : r_q + CNT_W'(1);
        end
    end

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clear_i) begin
            r_d = '0;
            c_d = '0;
        end else if (inc_i) begin
            r_d = r_nxt_o;
            c_d = c_nxt_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign last_o     = (r_q == n_max) && (c_q == n_max);
    assign nxt_last_o = (r_nxt_o == n_max) && (c_nxt_o == n_max);
`ifdef RESULT_TX_ROW_MARK_EN
    assign nxt_row_end_o = (c_nxt_o == n_max);
`endif

endmodule

// File: rtl/result_stream_tx.sv
// AXI4-Stream master draining the captured N x N result sub-matrix row-major, TLAST on the final element.
// Macro RESULT_TX_ROW_MARK_EN drives m_axis_user high on row-end beats; otherwise it is tied low.
module result_stream_tx
    import matmul_pkg::*;
(
    input  logic                             axi_clk,
    input  logic                             axi_rst,
    input  logic [N_W-1:0]                   N,
    input  logic                             GLOBAL_DONE,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] C_matrix,
    output logic [DATA_WIDTH-1:0]            m_axis_data,
    output logic                             m_axis_valid,
    input  logic                             m_axis_ready,
    output logic                             m_axis_last,
    output logic                             m_axis_user,
    output logic                             busy,
    output logic                             overrun,
    output logic                             n_err
);

    tx_state_t             state_q, state_d;
    tx_beat_t              beat_q, beat_d;
    logic [CNT_W-1:0]      n_act_q, n_act_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  n_err_q, n_err_d;
    logic                  done_prev_q;
    logic [DATA_WIDTH-1:0] shadow_q [ARRAY_SIZE];

    logic                  done_rise_c;
    logic                  capture_c;
    logic                  inc_c;
    logic [CNT_W-1:0]      n_new_c;
    logic [DATA_WIDTH-1:0] elem0_c;
    logic [DATA_WIDTH-1:0] nxt_data_c;
    logic [CNT_W-1:0]      r_nxt_c, c_nxt_c;
    logic                  last_c, nxt_last_c;
`ifdef RESULT_TX_ROW_MARK_EN
    logic                  user_q, user_d;
    logic                  nxt_row_end_c;
`endif

    assign done_rise_c = GLOBAL_DONE & ~done_prev_q;
    assign n_new_c     = (N > N_W'(SIZE)) ? CNT_W'(SIZE) : CNT_W'(N);
    // First beat bypasses the shadow, which is being loaded on the same edge
    assign elem0_c     = C_matrix[ARRAY_SIZE*DATA_WIDTH-1 -: DATA_WIDTH];
    assign nxt_data_c  = shadow_q[elem_idx(r_nxt_c, c_nxt_c)];

    rc_counter u_rc (
        .clk_i        (axi_clk),
        .rst_i        (axi_rst),
        .clear_i      (capture_c),
        .inc_i        (inc_c),
        .n_act_i      (n_act_q),
        .r_nxt_o      (r_nxt_c),
        .c_nxt_o      (c_nxt_c),
        .last_o       (last_c),
        .nxt_last_o   (nxt_last_c)
`ifdef RESULT_TX_ROW_MARK_EN
        ,
        .nxt_row_end_o(nxt_row_end_c)
`endif
    );

    // FSM next-state and output-register loads
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        n_act_d   = n_act_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        n_err_d   = n_err_q;
        capture_c = 1'b0;
        inc_c     = 1'b0;
`ifdef RESULT_TX_ROW_MARK_EN
        user_d    = user_q;
`endif
        case (state_q)
            IDLE: begin
                if (done_rise_c) begin
                    if (N == '0) begin
                        n_err_d = 1'b1;
                    end else begin
                        capture_c   = 1'b1;
                        state_d     = SEND;
                        n_act_d     = n_new_c;
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                        beat_d.data = elem0_c;
                        beat_d.last = (n_new_c == CNT_W'(1));
`ifdef RESULT_TX_ROW_MARK_EN
                        user_d      = (n_new_c == CNT_W'(1));
`endif
                    end
                end
            end
            SEND: begin
                if (done_rise_c) begin
                    overrun_d = 1'b1;
                end
                if (valid_q && m_axis_ready) begin
                    inc_c = 1'b1;
                    if (last_c) begin
                        state_d     = IDLE;
                        valid_d     = 1'b0;
                        busy_d      = 1'b0;
                        beat_d.last = 1'b0;
`ifdef RESULT_TX_ROW_MARK_EN
                        user_d      = 1'b0;
`endif
                    end else begin
                        beat_d.data = nxt_data_c;
                        beat_d.last = nxt_last_c;
`ifdef RESULT_TX_ROW_MARK_EN
                        user_d      = nxt_row_end_c;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            n_act_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            n_err_q     <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            n_act_q     <= n_act_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            n_err_q     <= n_err_d;
            done_prev_q <= GLOBAL_DONE;
        end
    end

    // Shadow copy frees the scheduler as soon as the frame is captured
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int k = 0; k < ARRAY_SIZE; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (capture_c) begin
            for (int k = 0; k < ARRAY_SIZE; k++) begin
                shadow_q[k] <= C_matrix[(ARRAY_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef RESULT_TX_ROW_MARK_EN
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            user_q <= 1'b0;
        end else begin
            user_q <= user_d;
        end
    end
    assign m_axis_user = user_q;
`else
    assign m_axis_user = 1'b0;
`endif

    assign m_axis_data  = beat_q.data;
    assign m_axis_last  = beat_q.last;
    assign m_axis_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign n_err        = n_err_q;

endmodule

// File: tb/tb_result_stream_tx.sv
// Self-checking bench for result_stream_tx: table of frame scenarios plus randomized frames and reset/overrun sequences.
// Row-end expectations follow RESULT_TX_ROW_MARK_EN.
module tb_result_stream_tx;
    import matmul_pkg::*;

    localparam int unsigned AW = ARRAY_SIZE * DATA_WIDTH;

    logic                  axi_clk = 1'b0;
    logic                  axi_rst;
    logic [N_W-1:0]        N;
    logic                  GLOBAL_DONE;
    logic [AW-1:0]         C_matrix;
    logic [DATA_WIDTH-1:0] m_axis_data;
    logic                  m_axis_valid;
    logic                  m_axis_ready;
    logic                  m_axis_last;
    logic                  m_axis_user;
    logic                  busy;
    logic                  overrun;
    logic                  n_err;

    always #5 axi_clk = ~axi_clk;

    result_stream_tx dut (
        .axi_clk     (axi_clk),
        .axi_rst     (axi_rst),
        .N           (N),
        .GLOBAL_DONE (GLOBAL_DONE),
        .C_matrix    (C_matrix),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last),
        .m_axis_user (m_axis_user),
        .busy        (busy),
        .overrun     (overrun),
        .n_err       (n_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        int n;
        int rmode;      // 0: ready held high, 1: toggles, 2: random
        bit rnd;        // random payload instead of C[k]=k+1
        bit hold;       // keep GLOBAL_DONE high past frame end
        bit repulse;    // second GLOBAL_DONE edge mid-frame
        int exp_beats;  // beat index carrying TLAST (0: no frame)
    } vec_t;

    int          vectors;
    int          miscompares;
    bit          exp_overrun;
    bit          exp_n_err;
    int unsigned c_arr [ARRAY_SIZE];
    beat_t       exp_q [$];
    vec_t        tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_c(input bit rnd);
        for (int k = 0; k < int'(ARRAY_SIZE); k++) begin
            c_arr[k] = rnd ? $urandom : 32'(k + 1);
        end
        C_matrix = '0;
        for (int k = 0; k < int'(ARRAY_SIZE); k++) begin
            C_matrix = {C_matrix[AW-DATA_WIDTH-1:0], DATA_WIDTH'(c_arr[k])};
        end
    endtask

    // Reference: clamp N, walk the na x na corner row-major
    task automatic build_expected(input int n);
        int    na;
        beat_t e;
        na = (n > int'(SIZE)) ? int'(SIZE) : n;
        exp_q.delete();
        for (int r = 0; r < na; r++) begin
            for (int c = 0; c < na; c++) begin
                e.data = c_arr[r * int'(SIZE) + c];
                e.last = (r == na - 1) && (c == na - 1);
`ifdef RESULT_TX_ROW_MARK_EN
                e.user = (c == na - 1);
`else
                e.user = 1'b0;
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_frame(input int n, input int rmode, input bit rnd, input bit hold,
                             input bit repulse, input int exp_beats);
        int    beats, last_at, cyc;
        bit    held;
        beat_t e, prev;
        load_c(rnd);
        build_expected(n);
        @(negedge axi_clk);
        N = N_W'(n);
        GLOBAL_DONE = 1'b1;
        @(negedge axi_clk);
        if (!hold) GLOBAL_DONE = 1'b0;
        if (exp_q.size() == 0) begin
            exp_n_err = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk("nerr_no_valid", 32'(m_axis_valid), 32'd0);
                @(negedge axi_clk);
            end
            chk("nerr_busy", 32'(busy), 32'd0);
            chk("nerr_flag", 32'(n_err), 32'(exp_n_err));
            GLOBAL_DONE = 1'b0;
            return;
        end
        chk("first_valid", 32'(m_axis_valid), 32'd1);
        beats = 0; last_at = 0; cyc = 0; held = 1'b0;
        prev = '{32'd0, 1'b0, 1'b0};
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (rmode == 0)      m_axis_ready = 1'b1;
            else if (rmode == 1) m_axis_ready = (cyc % 2 == 0);
            else                 m_axis_ready = ($urandom_range(0, 1) == 1);
            if (repulse) begin
                if (cyc == 2) begin
                    GLOBAL_DONE = 1'b1;
                    C_matrix = ~C_matrix;
                    exp_overrun = 1'b1;
                end else if (cyc == 3) begin
                    GLOBAL_DONE = 1'b0;
                end
            end
            chk("valid_mid", 32'(m_axis_valid), 32'd1);
            if (held) begin
                chk("hold_data", m_axis_data, prev.data);
                chk("hold_last", 32'(m_axis_last), 32'(prev.last));
                chk("hold_user", 32'(m_axis_user), 32'(prev.user));
            end
            if (m_axis_valid && m_axis_ready) begin
                e = exp_q.pop_front();
                beats++;
                chk("data", m_axis_data, e.data);
                chk("last", 32'(m_axis_last), 32'(e.last));
                chk("user", 32'(m_axis_user), 32'(e.user));
                chk("busy", 32'(busy), 32'd1);
                if (m_axis_last && last_at == 0) last_at = beats;
            end
            held = m_axis_valid && !m_axis_ready;
            prev.data = m_axis_data;
            prev.last = m_axis_last;
            prev.user = m_axis_user;
            @(negedge axi_clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        chk("last_pos", 32'(last_at), 32'(exp_beats));
        chk("end_valid", 32'(m_axis_valid), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("overrun", 32'(overrun), 32'(exp_overrun));
        chk("n_err", 32'(n_err), 32'(exp_n_err));
        if (hold) begin
            repeat (5) @(negedge axi_clk);
            chk("no_retrigger", 32'(m_axis_valid), 32'd0);
            chk("hold_overrun", 32'(overrun), 32'(exp_overrun));
            GLOBAL_DONE = 1'b0;
        end
        m_axis_ready = 1'b0;
    endtask

    initial begin
        int beats, cyc, n;
        vectors = 0; miscompares = 0;
        exp_overrun = 1'b0; exp_n_err = 1'b0;
        axi_rst = 1'b1; N = '0; GLOBAL_DONE = 1'b0; C_matrix = '0; m_axis_ready = 1'b0;

        tbl[0] = '{6, 0, 0, 0, 0, 36};
        tbl[1] = '{3, 0, 0, 0, 0, 9};
        tbl[2] = '{4, 1, 0, 0, 0, 16};
        tbl[3] = '{1, 0, 1, 0, 0, 1};
        tbl[4] = '{9, 0, 0, 0, 0, 36};
        tbl[5] = '{0, 0, 0, 0, 0, 0};
        tbl[6] = '{5, 2, 1, 0, 0, 25};
        tbl[7] = '{2, 0, 1, 1, 0, 4};

        repeat (2) @(negedge axi_clk);
        chk("rst_valid", 32'(m_axis_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", m_axis_data, 32'd0);
        chk("rst_last", 32'(m_axis_last), 32'd0);
        chk("rst_user", 32'(m_axis_user), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_n_err", 32'(n_err), 32'd0);
        axi_rst = 1'b0;
        repeat (2) @(negedge axi_clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].n, tbl[i].rmode, tbl[i].rnd, tbl[i].hold, tbl[i].repulse, tbl[i].exp_beats);
        end

        // Second GLOBAL_DONE edge mid-frame: original frame completes, overrun latches
        run_frame(2, 0, 1, 0, 1, 4);
        repeat (5) @(negedge axi_clk);
        chk("no_second_frame", 32'(m_axis_valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(1, 9));
            run_frame(n, 2, 1, 0, 0, (n > int'(SIZE)) ? int'(SIZE * SIZE) : n * n);
        end

        // Asynchronous reset in the middle of an N=6 frame
        load_c(1'b0);
        m_axis_ready = 1'b1;
        @(negedge axi_clk);
        N = 4'd6;
        GLOBAL_DONE = 1'b1;
        @(negedge axi_clk);
        GLOBAL_DONE = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 5 && cyc < 100) begin
            if (m_axis_valid && m_axis_ready) beats++;
            @(negedge axi_clk);
            cyc++;
        end
        chk("pre_reset_data", m_axis_data, 32'd6);
        axi_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(m_axis_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", m_axis_data, 32'd0);
        chk("mid_rst_last", 32'(m_axis_last), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_n_err", 32'(n_err), 32'd0);
        exp_overrun = 1'b0;
        exp_n_err = 1'b0;
        @(negedge axi_clk);
        axi_rst = 1'b0;
        m_axis_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_clk);
            chk("post_rst_idle", 32'(m_axis_valid), 32'd0);
        end
        run_frame(1, 0, 1, 0, 0, 1);
        run_frame(3, 1, 1, 0, 0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
